rob_recovery_ctrl: RTL and testbench
====================================

// Module: rob_recovery_ctrl
// PURPOSE
// - Drives ROB misprediction/exception recovery. It sources rob_state and flush_valid for the stall/flush controller.
// - A redirect at commit causes, in order: a one-cycle front-end flush, a rollback drain, and a backward walk over the
//   squashed ROB entries (youngest first) for rename-map restore, then a tail-pointer restore.
// - Sits between the commit stage/ROB pointers and the front-end stall/flush logic and rename table.
// PARAMETERS
// - ROB_DEPTH        32  ROB entries; power of two.
// - WALK_WIDTH       2   max entries walked per cycle.
// - ROLLBACK_CYCLES  2   cycles spent in rob_rollback (FU/pipeline drain); must be >= 1.
// - PTR_W            $clog2(ROB_DEPTH), derived (localparam).
// PORTS
// - clk                     in   1                 clock; all state updates on posedge.
// - reset                   in   1                 synchronous, active-high.
// - commit_redirect_valid   in   1                 commit head is a mispredicted branch/exception.
// - commit_redirect_rob_idx in   PTR_W             ROB index of the redirecting entry.
// - commit_redirect_pc      in   32                correct next PC.
// - rob_tail                in   PTR_W             ROB tail (next free slot), sampled with the redirect.
// - rob_full                in   1                 ROB full, sampled with the redirect.
// - rob_state               out  2                 rob_idle / rob_rollback / rob_walk.
// - flush_valid             out  1                 one-cycle flush pulse.
// - redirect_pc             out  32                valid while flush_valid=1.
// - walk_valid              out  WALK_WIDTH        per-slot valid; slot0 is the youngest.
// - walk_idx                out  WALK_WIDTH*PTR_W  per-slot ROB index being undone.
// - rob_tail_restore_valid  out  1                 one-cycle pulse.
// - rob_tail_restore        out  PTR_W             new tail = redirect_idx+1 (mod ROB_DEPTH).
// BEHAVIOUR
// - Reset (sync) and reset mid-operation:
//   - Next cycle: rob_state=rob_idle; all valids/pulses 0; redirect_pc, walk_idx, rob_tail_restore = 0.
//   - Any walk in progress is abandoned.
// - All outputs are registered.
// - FSM IDLE: on commit_redirect_valid at cycle T, latch idx, pc, start=rob_tail-1, and count:
//   - count = rob_full && rob_tail==idx ? ROB_DEPTH-1 : (rob_tail-idx-1) mod ROB_DEPTH.
//   - Go to ROLLBACK.
// - ROLLBACK: rob_state=rob_rollback for exactly ROLLBACK_CYCLES cycles (T+1..T+R).
//   - flush_valid=1 and redirect_pc valid in cycle T+1 only.
//   - Exit to WALK if count>0, else to IDLE.
// - WALK: each cycle, n = min(WALK_WIDTH, remaining).
//   - Slot k (k<n): walk_valid[k]=1, walk_idx[k]=cur-k (mod ROB_DEPTH).
//   - Then cur -= n, remaining -= n.
//   - Slots k>=n have walk_valid=0.
//   - Leave when remaining reaches 0 after this cycle.
// - IDLE entry after recovery: rob_tail_restore_valid=1 for 1 cycle with idx+1 (mod ROB_DEPTH).
//   - A redirect seen in that same cycle is accepted normally.
// - Redirects while not IDLE are ignored; younger work was already squashed.
// - Wrap-around: all pointer arithmetic is modulo ROB_DEPTH in PTR_W bits; no overflow flag.
// - rob_state is never a value other than the three encodings. Counters are PTR_W+1 bits wide.
// STRUCTURE
// - Shared package common: rob_state_t enum with encodings
//   - rob_idle=2'b00, rob_rollback=2'b01, rob_walk=2'b10.
//   - This encoding is already consumed by the stall/flush controller.
// - Also in common: ROB_DEPTH constant.
// - Sub-module: rob_walk_gen. Combinational: cur and remaining -> walk_valid/walk_idx.
// - FSM and counters live in the top module.
// TESTING (ROB_DEPTH=32, WALK_WIDTH=2, ROLLBACK_CYCLES=2; redirect at cycle T)
// - Basic: idx=5, tail=10 ->
//   - T+1 flush_valid=1, redirect_pc echoed; rollback T+1..T+2.
//   - Walk T+3 {9,8}, T+4 {7,6}.
//   - T+5 idle, tail_restore=6.
// - Odd count: idx=5, tail=9 ->
//   - Walk {8,7}, then {6} with walk_valid=2'b01.
//   - tail_restore=6.
// - Wrap: idx=30, tail=2 -> walk {1,0}, then {31}; tail_restore=31.
// - Full: rob_full=1, tail=idx=4 ->
//   - 31 entries over 16 walk cycles.
//   - Last cycle {5} with valid=2'b01; tail_restore=5.
// - Empty walk: idx=7, tail=8 ->
//   - Rollback T+1..T+2; no walk_valid ever.
//   - T+3 idle with tail_restore=8.
// - Interference:
//   - A redirect during rollback/walk leaves the sequence unchanged.
//   - reset asserted mid-walk -> next cycle rob_idle, all outputs 0, no tail_restore pulse.

Source files
------------

// File: rtl/rob_recovery_ctrl_pkg.sv
// rob_recovery_ctrl_pkg: shared ROB recovery state encoding and sizing.
package rob_recovery_ctrl_pkg;
    localparam int ROB_DEPTH = 32;
    typedef enum logic [1:0] {
        rob_idle     = 2'b00,
        rob_rollback = 2'b01,
        rob_walk     = 2'b10
    } rob_state_t;
endpackage

// File: rtl/rob_recovery_ctrl_walk_gen.sv
// rob_recovery_ctrl_walk_gen: expands a walk cursor and remaining count into per-slot undo indices.
module rob_recovery_ctrl_walk_gen
    import rob_recovery_ctrl_pkg::*;
#(
    parameter int PTR_W      = 5,
    parameter int WALK_WIDTH = 2
) (
    input  logic [PTR_W-1:0]            i_cur,
    input  logic [PTR_W:0]              i_rem,
    output logic [WALK_WIDTH-1:0]       o_walk_valid,
    output logic [WALK_WIDTH*PTR_W-1:0] o_walk_idx,
    output logic [PTR_W:0]              o_n
);
    localparam int CW = PTR_W + 1;
    for (genvar k = 0; k < WALK_WIDTH; k++) begin : g_slot
        assign o_walk_valid[k]               = i_rem > CW'(k);
        assign o_walk_idx[k*PTR_W +: PTR_W]  = i_cur - PTR_W'(k);
    end
    assign o_n = (i_rem > CW'(WALK_WIDTH)) ? CW'(WALK_WIDTH) : i_rem;
endmodule

// File: rtl/rob_recovery_ctrl.sv
// rob_recovery_ctrl: sequences flush, rollback drain, youngest-first rename walk and tail restore after a commit redirect.
module rob_recovery_ctrl #(
    parameter int ROB_DEPTH       = rob_recovery_ctrl_pkg::ROB_DEPTH,
    parameter int WALK_WIDTH      = 2,
    parameter int ROLLBACK_CYCLES = 2,
    localparam int PTR_W          = $clog2(ROB_DEPTH)
) (
    input  logic                        i_clk,
    input  logic                        i_reset,
    input  logic                        i_commit_redirect_valid,
    input  logic [PTR_W-1:0]            i_commit_redirect_rob_idx,
    input  logic [31:0]                 i_commit_redirect_pc,
    input  logic [PTR_W-1:0]            i_rob_tail,
    input  logic                        i_rob_full,
    output logic [1:0]                  o_rob_state,
    output logic                        o_flush_valid,
    output logic [31:0]                 o_redirect_pc,
    output logic [WALK_WIDTH-1:0]       o_walk_valid,
    output logic [WALK_WIDTH*PTR_W-1:0] o_walk_idx,
    output logic                        o_rob_tail_restore_valid,
    output logic [PTR_W-1:0]            o_rob_tail_restore
);
    import rob_recovery_ctrl_pkg::*;
    localparam int CW = PTR_W + 1;
    rob_state_t                  r_state;
    logic                        r_flush, r_tr_valid;
    logic [31:0]                 r_pc;
    logic [WALK_WIDTH-1:0]       r_walk_valid, w_walk_valid;
    logic [WALK_WIDTH*PTR_W-1:0] r_walk_idx, w_walk_idx;
    logic [PTR_W-1:0]            r_idx, r_cur, r_tr, w_diff;
    logic [CW-1:0]               r_rem, r_rb, w_count, w_n;
    logic                        w_walk_turn, w_step, w_finish;
    // A full ROB with tail==idx means every other entry is younger and must be undone.
    assign w_diff      = i_rob_tail - i_commit_redirect_rob_idx - PTR_W'(1);
    assign w_count     = (i_rob_full && i_rob_tail == i_commit_redirect_rob_idx) ? CW'(ROB_DEPTH - 1) : {1'b0, w_diff};
    assign w_walk_turn = (r_state == rob_rollback && r_rb == '0) || r_state == rob_walk;
    assign w_step      = w_walk_turn && r_rem != '0;
    assign w_finish    = w_walk_turn && r_rem == '0;
    rob_recovery_ctrl_walk_gen #(.PTR_W(PTR_W), .WALK_WIDTH(WALK_WIDTH)) u_walk_gen (
        .i_cur        (r_cur),
        .i_rem        (r_rem),
        .o_walk_valid (w_walk_valid),
        .o_walk_idx   (w_walk_idx),
        .o_n          (w_n)
    );
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state      <= rob_idle;
            r_flush      <= 1'b0;
            r_pc         <= '0;
            r_walk_valid <= '0;
            r_walk_idx   <= '0;
            r_tr_valid   <= 1'b0;
            r_tr         <= '0;
            r_idx        <= '0;
            r_cur        <= '0;
            r_rem        <= '0;
            r_rb         <= '0;
        end else begin
            r_flush      <= 1'b0;
            r_tr_valid   <= 1'b0;
            r_walk_valid <= '0;
            r_walk_idx   <= '0;
            if (w_step) begin
                r_state      <= rob_walk;
                r_walk_valid <= w_walk_valid;
                r_walk_idx   <= w_walk_idx;
                r_cur        <= r_cur - w_n[PTR_W-1:0];
                r_rem        <= r_rem - w_n;
            end else if (w_finish) begin
                r_state    <= rob_idle;
                r_tr_valid <= 1'b1;
                r_tr       <= r_idx + PTR_W'(1);
            end else if (r_state == rob_rollback) begin
                r_rb <= r_rb - CW'(1);
            end else if (r_state == rob_idle && i_commit_redirect_valid) begin
                r_state <= rob_rollback;
                r_flush <= 1'b1;
                r_pc    <= i_commit_redirect_pc;
                r_idx   <= i_commit_redirect_rob_idx;
                r_cur   <= i_rob_tail - PTR_W'(1);
                r_rem   <= w_count;
                r_rb    <= CW'(ROLLBACK_CYCLES - 1);
            end
        end
    end
    assign o_rob_state              = r_state;
    assign o_flush_valid            = r_flush;
    assign o_redirect_pc            = r_pc;
    assign o_walk_valid             = r_walk_valid;
    assign o_walk_idx               = r_walk_idx;
    assign o_rob_tail_restore_valid = r_tr_valid;
    assign o_rob_tail_restore       = r_tr;
endmodule

// File: tb/tb_rob_recovery_ctrl.sv
// tb_rob_recovery_ctrl: scoreboard bench for the ROB recovery sequencer (depth 32, walk width 2, rollback 2).
module tb_rob_recovery_ctrl;
    typedef struct packed {
        logic [1:0]  st;
        logic        fl;
        logic [31:0] pc;
        logic [1:0]  wv;
        logic [4:0]  wi1;
        logic [4:0]  wi0;
        logic        trv;
        logic [4:0]  tr;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        rv = 1'b0;
    logic [4:0]  ridx = '0;
    logic [31:0] rpc = '0;
    logic [4:0]  tail = '0;
    logic        full = 1'b0;
    logic [1:0]  rob_state;
    logic        flush_valid;
    logic [31:0] redirect_pc;
    logic [1:0]  walk_valid;
    logic [9:0]  walk_idx;
    logic        tr_valid;
    logic [4:0]  tr;
    exp_t        sb[$];
    int          vectors = 0;
    int          miscompares = 0;

    always #5 clk = ~clk;

    rob_recovery_ctrl #(.ROB_DEPTH(32), .WALK_WIDTH(2), .ROLLBACK_CYCLES(2)) dut (
        .i_clk                     (clk),
        .i_reset                   (reset),
        .i_commit_redirect_valid   (rv),
        .i_commit_redirect_rob_idx (ridx),
        .i_commit_redirect_pc      (rpc),
        .i_rob_tail                (tail),
        .i_rob_full                (full),
        .o_rob_state               (rob_state),
        .o_flush_valid             (flush_valid),
        .o_redirect_pc             (redirect_pc),
        .o_walk_valid              (walk_valid),
        .o_walk_idx                (walk_idx),
        .o_rob_tail_restore_valid  (tr_valid),
        .o_rob_tail_restore        (tr)
    );

    function automatic exp_t mk(input logic [1:0] st, input logic fl, input logic [31:0] pc, input logic [1:0] wv,
                                input logic [4:0] i1, input logic [4:0] i0, input logic trv, input logic [4:0] t);
        exp_t e;
        e.st  = st;
        e.fl  = fl;
        e.pc  = fl ? pc : 32'd0;
        e.wv  = wv;
        e.wi1 = wv[1] ? i1 : 5'd0;
        e.wi0 = wv[0] ? i0 : 5'd0;
        e.trv = trv;
        e.tr  = trv ? t : 5'd0;
        return e;
    endfunction

    function automatic exp_t observed();
        return mk(rob_state, flush_valid, redirect_pc, walk_valid, walk_idx[9:5], walk_idx[4:0], tr_valid, tr);
    endfunction

    // Reference: squashed entries are walked from tail-1 downward, two per cycle, after two rollback cycles.
    task automatic push_model(input logic [4:0] idx, input logic [4:0] t, input logic f, input logic [31:0] pc);
        logic [4:0] cur;
        logic [4:0] d;
        int         rem;
        d   = t - idx - 5'd1;
        rem = (f && t == idx) ? 31 : int'(d);
        cur = t - 5'd1;
        sb.push_back(mk(2'b01, 1'b1, pc, 2'b00, 5'd0, 5'd0, 1'b0, 5'd0));
        sb.push_back(mk(2'b01, 1'b0, 32'd0, 2'b00, 5'd0, 5'd0, 1'b0, 5'd0));
        while (rem > 0) begin
            if (rem >= 2) begin
                sb.push_back(mk(2'b10, 1'b0, 32'd0, 2'b11, cur - 5'd1, cur, 1'b0, 5'd0));
                cur = cur - 5'd2;
                rem = rem - 2;
            end else begin
                sb.push_back(mk(2'b10, 1'b0, 32'd0, 2'b01, 5'd0, cur, 1'b0, 5'd0));
                cur = cur - 5'd1;
                rem = 0;
            end
        end
        sb.push_back(mk(2'b00, 1'b0, 32'd0, 2'b00, 5'd0, 5'd0, 1'b1, idx + 5'd1));
    endtask

    task automatic drive_redirect(input logic [4:0] idx, input logic [4:0] t, input logic f, input logic [31:0] pc);
        rv = 1'b1; ridx = idx; tail = t; full = f; rpc = pc;
    endtask

    task automatic run_seq(input string name, input int junk_at);
        exp_t e;
        exp_t a;
        int   j;
        j = 0;
        while (sb.size() > 0 && j < 100) begin
            @(posedge clk);
            #1;
            rv = 1'b0;
            if (j == junk_at) drive_redirect(5'd17, 5'd3, 1'b1, 32'hDEAD_BEEF);
            @(negedge clk);
            e = sb.pop_front();
            a = observed();
            vectors++;
            if (a !== e) begin
                miscompares++;
                $display("FAIL %s step %0d: got %h expected %h", name, j, a, e);
            end
            j++;
        end
        rv = 1'b0;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL %s timeout: %0d vectors left, expected 0", name, sb.size());
            sb.delete();
        end
    endtask

    task automatic check_raw_idle(input string name);
        vectors++;
        if (rob_state !== 2'b00 || flush_valid !== 1'b0 || redirect_pc !== 32'd0 || walk_valid !== 2'b00 ||
            walk_idx !== 10'd0 || tr_valid !== 1'b0 || tr !== 5'd0) begin
            miscompares++;
            $display("FAIL %s: got st=%b fl=%b pc=%h wv=%b wi=%h trv=%b tr=%0d expected all zero",
                     name, rob_state, flush_valid, redirect_pc, walk_valid, walk_idx, tr_valid, tr);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_raw_idle("reset");
        reset = 1'b0;
        @(negedge clk);
        check_raw_idle("post_reset_idle");
    endtask

    task automatic test_basic();
        drive_redirect(5'd5, 5'd10, 1'b0, 32'h0000_1234);
        sb.push_back(mk(2'b01, 1'b1, 32'h0000_1234, 2'b00, 5'd0, 5'd0, 1'b0, 5'd0));
        sb.push_back(mk(2'b01, 1'b0, 32'd0, 2'b00, 5'd0, 5'd0, 1'b0, 5'd0));
        sb.push_back(mk(2'b10, 1'b0, 32'd0, 2'b11, 5'd8, 5'd9, 1'b0, 5'd0));
        sb.push_back(mk(2'b10, 1'b0, 32'd0, 2'b11, 5'd6, 5'd7, 1'b0, 5'd0));
        sb.push_back(mk(2'b00, 1'b0, 32'd0, 2'b00, 5'd0, 5'd0, 1'b1, 5'd6));
        run_seq("basic", -1);
    endtask

    task automatic test_odd();
        drive_redirect(5'd5, 5'd9, 1'b0, 32'hCAFE_0004);
        push_model(5'd5, 5'd9, 1'b0, 32'hCAFE_0004);
        run_seq("odd", -1);
    endtask

    task automatic test_wrap();
        drive_redirect(5'd30, 5'd2, 1'b0, 32'h8000_0000);
        push_model(5'd30, 5'd2, 1'b0, 32'h8000_0000);
        run_seq("wrap", -1);
    endtask

    task automatic test_full();
        drive_redirect(5'd4, 5'd4, 1'b1, 32'h0BAD_F00D);
        push_model(5'd4, 5'd4, 1'b1, 32'h0BAD_F00D);
        run_seq("full", -1);
    endtask

    task automatic test_empty();
        drive_redirect(5'd7, 5'd8, 1'b0, 32'h0000_0700);
        push_model(5'd7, 5'd8, 1'b0, 32'h0000_0700);
        run_seq("empty", -1);
    endtask

    task automatic test_interference();
        drive_redirect(5'd12, 5'd20, 1'b0, 32'h1111_2222);
        push_model(5'd12, 5'd20, 1'b0, 32'h1111_2222);
        run_seq("ignore_in_rollback", 1);
        drive_redirect(5'd12, 5'd20, 1'b0, 32'h3333_4444);
        push_model(5'd12, 5'd20, 1'b0, 32'h3333_4444);
        run_seq("ignore_in_walk", 3);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 3; i++) begin
            logic [4:0] idx;
            logic [4:0] t;
            idx = 5'($urandom_range(0, 31));
            t   = idx + 5'($urandom_range(1, 9));
            drive_redirect(idx, t, 1'b0, 32'($urandom));
            push_model(idx, t, 1'b0, rpc);
            run_seq("back_to_back", -1);
        end
    endtask

    task automatic test_reset_mid();
        exp_t e;
        drive_redirect(5'd4, 5'd4, 1'b1, 32'h5555_AAAA);
        push_model(5'd4, 5'd4, 1'b1, 32'h5555_AAAA);
        for (int j = 0; j < 5; j++) begin
            @(posedge clk);
            #1;
            rv = 1'b0;
            @(negedge clk);
            e = sb.pop_front();
            vectors++;
            if (observed() !== e) begin
                miscompares++;
                $display("FAIL reset_mid pre step %0d: got %h expected %h", j, observed(), e);
            end
        end
        sb.delete();
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check_raw_idle("reset_mid_walk");
        repeat (3) begin
            @(negedge clk);
            check_raw_idle("reset_mid_no_resume");
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_odd();
        test_wrap();
        test_full();
        test_empty();
        test_interference();
        test_back_to_back();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
